// File: rtl/flash_hv_pulse_ctrl.sv
// flash_hv_pulse_ctrl: turns sequencer strobes into timed charge-pump, HV pulse and discharge controls
// for the flash analog macro, with busy/done status and a sticky protocol error.
module flash_hv_pulse_ctrl #(
    parameter int PUMP_SETTLE = 16,
    parameter int PROG_PULSE  = 8,
    parameter int ERASE_PULSE = 64,
    parameter int DISCHARGE   = 4,
    parameter int CW          = 8
) (
    input  logic clkm,
    input  logic rst_n,
    input  logic analog_on2,
    input  logic en_wr,
    input  logic erase,
    input  logic erase_clr,
    input  logic err_clr,
    output logic pump_en,
    output logic hv_ready,
    output logic prog_pulse,
    output logic erase_pulse,
    output logic discharge,
    output logic busy,
    output logic done,
    output logic err
);
    typedef enum logic [2:0] {IDLE, SETTLE, READY, PROG, ERASE, DISCH} state_t;

    localparam logic [CW-1:0] LD_SETTLE = CW'(PUMP_SETTLE - 1);
    localparam logic [CW-1:0] LD_PROG   = CW'(PROG_PULSE - 1);
    localparam logic [CW-1:0] LD_ERASE  = CW'(ERASE_PULSE - 1);
    localparam logic [CW-1:0] LD_DISCH  = CW'(DISCHARGE - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          pend, pend_nx, err_set, expired;
    logic          pump_nx, hv_nx, prog_nx, erase_nx, disch_nx, busy_nx, done_nx, err_nx;

    assign expired = cnt == '0;

    always_ff @(posedge clkm or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pend        <= 1'b0;
            pump_en     <= 1'b0;
            hv_ready    <= 1'b0;
            prog_pulse  <= 1'b0;
            erase_pulse <= 1'b0;
            discharge   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            pend        <= pend_nx;
            pump_en     <= pump_nx;
            hv_ready    <= hv_nx;
            prog_pulse  <= prog_nx;
            erase_pulse <= erase_nx;
            discharge   <= disch_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            err         <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = analog_on2 ? SETTLE : IDLE;
            SETTLE:  state_nx = !analog_on2 ? DISCH : expired ? READY : SETTLE;
            READY:   state_nx = !analog_on2 ? DISCH : (erase_clr && erase) ? ERASE :
                                (en_wr || pend) ? PROG : READY;
            PROG:    state_nx = !analog_on2 ? DISCH : expired ? READY : PROG;
            ERASE:   state_nx = !analog_on2 ? DISCH : expired ? READY : ERASE;
            DISCH:   state_nx = expired ? IDLE : DISCH;
            default: state_nx = IDLE;
        endcase
    end

    // Counter reloads on every state change so each timed state lasts exactly N cycles
    always_comb begin
        cnt_nx = (state_nx == state) ? (expired ? cnt : cnt - CW'(1)) :
                 (state_nx == SETTLE) ? LD_SETTLE :
                 (state_nx == PROG)   ? LD_PROG :
                 (state_nx == ERASE)  ? LD_ERASE :
                 (state_nx == DISCH)  ? LD_DISCH : '0;
        pend_nx = (state_nx == DISCH && state != DISCH) ? 1'b0 :
                  (state == READY && state_nx == PROG)  ? 1'b0 :
                  (state == PROG && en_wr)              ? 1'b1 : pend;
        err_set = (state == IDLE)   ? en_wr :
                  (state == SETTLE) ? (en_wr || erase_clr) :
                  (state == READY)  ? (analog_on2 && erase && erase_clr && en_wr) :
                  (state == PROG)   ? (!analog_on2 || (en_wr && pend)) :
                  (state == ERASE)  ? (!analog_on2 || en_wr || erase_clr) : 1'b0;
    end

    always_comb begin
        pump_nx  = state_nx inside {SETTLE, READY, PROG, ERASE};
        hv_nx    = state_nx inside {READY, PROG, ERASE};
        prog_nx  = state_nx == PROG;
        erase_nx = state_nx == ERASE;
        disch_nx = state_nx == DISCH;
        busy_nx  = !(state_nx inside {IDLE, READY});
        done_nx  = (state == PROG || state == ERASE) && state_nx == READY;
        err_nx   = err_set || (err && !err_clr);
    end
endmodule

// File: tb/tb_flash_hv_pulse_ctrl.sv
// tb_flash_hv_pulse_ctrl: directed timeline checks plus randomized stimulus against a
// behavioural model tracking mode, remaining cycles, queued request and error flag.
module tb_flash_hv_pulse_ctrl;
    localparam int PUMP_SETTLE = 16, PROG_PULSE = 8, ERASE_PULSE = 64, DISCHARGE = 4;
    localparam int M_IDLE = 0, M_SET = 1, M_RDY = 2, M_PRG = 3, M_ERS = 4, M_DIS = 5;

    logic clkm = 0, rst_n = 0;
    logic analog_on2 = 0, en_wr = 0, erase = 0, erase_clr = 0, err_clr = 0;
    logic pump_en, hv_ready, prog_pulse, erase_pulse, discharge, busy, done, err;

    flash_hv_pulse_ctrl dut (
        .clkm(clkm), .rst_n(rst_n), .analog_on2(analog_on2), .en_wr(en_wr), .erase(erase),
        .erase_clr(erase_clr), .err_clr(err_clr), .pump_en(pump_en), .hv_ready(hv_ready),
        .prog_pulse(prog_pulse), .erase_pulse(erase_pulse), .discharge(discharge),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clkm = ~clkm;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int m_mode, m_left;
    logic m_pend, m_err, m_done;
    logic [7:0] hist [0:255];
    logic [7:0] outs;
    string bit_name [8] = '{"err", "done", "busy", "discharge", "erase_pulse", "prog_pulse", "hv_ready", "pump_en"};

    function automatic int dur(input int mode);
        return mode == M_SET ? PUMP_SETTLE : mode == M_PRG ? PROG_PULSE :
               mode == M_ERS ? ERASE_PULSE : mode == M_DIS ? DISCHARGE : 1;
    endfunction

    function automatic logic [7:0] exp_v();
        logic hv;
        hv = m_mode == M_RDY || m_mode == M_PRG || m_mode == M_ERS;
        return {hv || m_mode == M_SET, hv, m_mode == M_PRG, m_mode == M_ERS, m_mode == M_DIS,
                !(m_mode == M_IDLE || m_mode == M_RDY), m_done, m_err};
    endfunction

    task automatic model_step(input logic a, en, er, ec, cl);
        int nm;
        logic st, nd;
        nm = m_mode; st = 0; nd = 0;
        case (m_mode)
            M_IDLE: begin st = en; if (a) nm = M_SET; end
            M_SET: begin
                st = en | ec;
                if (!a) nm = M_DIS; else if (m_left == 1) nm = M_RDY;
            end
            M_RDY: begin
                if (!a) nm = M_DIS;
                else if (ec && er) begin nm = M_ERS; st = en; end
                else if (en || m_pend) begin nm = M_PRG; m_pend = 0; end
            end
            M_PRG: begin
                if (!a) begin nm = M_DIS; st = 1; end
                else begin
                    if (en) begin st = m_pend; m_pend = 1; end
                    if (m_left == 1) begin nm = M_RDY; nd = 1; end
                end
            end
            M_ERS: begin
                if (!a) begin nm = M_DIS; st = 1; end
                else begin
                    st = en | ec;
                    if (m_left == 1) begin nm = M_RDY; nd = 1; end
                end
            end
            default: if (m_left == 1) nm = M_IDLE;
        endcase
        if (nm == M_DIS && m_mode != M_DIS) m_pend = 0;
        m_left = (nm != m_mode) ? dur(nm) : m_left - 1;
        m_err = st ? 1'b1 : cl ? 1'b0 : m_err;
        m_mode = nm;
        m_done = nd;
    endtask

    task automatic tick(input logic a, en, er, ec, cl);
        analog_on2 = a; en_wr = en; erase = er; erase_clr = ec; err_clr = cl;
        model_step(a, en, er, ec, cl);
        @(posedge clkm); #1;
        cyc++;
        outs = {pump_en, hv_ready, prog_pulse, erase_pulse, discharge, busy, done, err};
        if (cyc < 256) hist[cyc] = outs;
        n_cmp++;
        if (outs !== exp_v()) begin
            n_bad++;
            $display("FAIL model cyc %0d got %b expected %b", cyc, outs, exp_v());
        end
    endtask

    task automatic do_reset();
        analog_on2 = 0; en_wr = 0; erase = 0; erase_clr = 0; err_clr = 0;
        rst_n = 0;
        @(posedge clkm); #1;
        rst_n = 1;
        cyc = 0;
        m_mode = M_IDLE; m_left = 1; m_pend = 0; m_err = 0; m_done = 0;
        hist[0] = {pump_en, hv_ready, prog_pulse, erase_pulse, discharge, busy, done, err};
    endtask

    task automatic settle();
        do_reset();
        repeat (20) tick(1, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        int chk [6][3] = '{'{1,7,1}, '{16,6,0}, '{17,6,1}, '{1,2,1}, '{16,2,1}, '{17,2,0}};
        settle();
        tick(1, 1, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({pump_en, hv_ready, prog_pulse, erase_pulse, discharge, busy, done, err} !== 8'h00) begin
            n_bad++;
            $display("FAIL async_reset got %b expected 00000000",
                     {pump_en, hv_ready, prog_pulse, erase_pulse, discharge, busy, done, err});
        end
        settle();
        n_cmp++;
        if (hist[0] !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state got %b expected 00000000", hist[0]);
        end
        foreach (chk[i]) begin
            n_cmp++;
            if (hist[chk[i][0]][chk[i][1]] !== 1'(chk[i][2])) begin
                n_bad++;
                $display("FAIL settle cyc %0d %s got %b expected %0d", chk[i][0],
                         bit_name[chk[i][1]], hist[chk[i][0]][chk[i][1]], chk[i][2]);
            end
        end
    endtask

    task automatic test_program();
        int chk [9][3] = '{'{20,5,0}, '{21,5,1}, '{28,5,1}, '{29,5,0}, '{28,1,0}, '{29,1,1},
                           '{30,1,0}, '{30,5,0}, '{31,0,0}};
        settle();
        repeat (12) tick(1, cyc == 20, 0, 0, 0);
        foreach (chk[i]) begin
            n_cmp++;
            if (hist[chk[i][0]][chk[i][1]] !== 1'(chk[i][2])) begin
                n_bad++;
                $display("FAIL program cyc %0d %s got %b expected %0d", chk[i][0],
                         bit_name[chk[i][1]], hist[chk[i][0]][chk[i][1]], chk[i][2]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int chk [9][3] = '{'{29,5,0}, '{30,5,1}, '{37,5,1}, '{38,5,0}, '{38,1,1}, '{25,0,0},
                           '{26,0,1}, '{39,5,0}, '{40,5,0}};
        settle();
        repeat (21) tick(1, cyc == 20 || cyc == 23 || cyc == 25, 0, 0, 0);
        foreach (chk[i]) begin
            n_cmp++;
            if (hist[chk[i][0]][chk[i][1]] !== 1'(chk[i][2])) begin
                n_bad++;
                $display("FAIL back_to_back cyc %0d %s got %b expected %0d", chk[i][0],
                         bit_name[chk[i][1]], hist[chk[i][0]][chk[i][1]], chk[i][2]);
            end
        end
    endtask

    task automatic test_erase();
        int chk [10][3] = '{'{42,4,0}, '{43,4,1}, '{106,4,1}, '{107,4,0}, '{106,1,0}, '{107,1,1},
                            '{60,0,0}, '{61,0,1}, '{43,5,0}, '{107,6,1}};
        settle();
        repeat (90) tick(1, cyc == 60, cyc >= 40 && cyc <= 42, cyc == 42, 0);
        foreach (chk[i]) begin
            n_cmp++;
            if (hist[chk[i][0]][chk[i][1]] !== 1'(chk[i][2])) begin
                n_bad++;
                $display("FAIL erase cyc %0d %s got %b expected %0d", chk[i][0],
                         bit_name[chk[i][1]], hist[chk[i][0]][chk[i][1]], chk[i][2]);
            end
        end
    endtask

    task automatic test_abort();
        int chk [12][3] = '{'{24,5,1}, '{25,5,0}, '{25,3,1}, '{28,3,1}, '{29,3,0}, '{25,7,0},
                            '{25,0,1}, '{28,2,1}, '{29,2,0}, '{29,1,0}, '{30,0,1}, '{31,0,0}};
        settle();
        repeat (12) tick(cyc < 24, cyc == 20, 0, 0, cyc == 30);
        foreach (chk[i]) begin
            n_cmp++;
            if (hist[chk[i][0]][chk[i][1]] !== 1'(chk[i][2])) begin
                n_bad++;
                $display("FAIL abort cyc %0d %s got %b expected %0d", chk[i][0],
                         bit_name[chk[i][1]], hist[chk[i][0]][chk[i][1]], chk[i][2]);
            end
        end
    endtask

    task automatic test_conflict();
        int chk [4][3] = '{'{20,0,0}, '{21,4,1}, '{21,5,0}, '{21,0,1}};
        int chk_idle [3][3] = '{'{1,0,1}, '{1,7,0}, '{1,2,0}};
        settle();
        repeat (3) tick(1, cyc == 20, cyc == 20, cyc == 20, 0);
        foreach (chk[i]) begin
            n_cmp++;
            if (hist[chk[i][0]][chk[i][1]] !== 1'(chk[i][2])) begin
                n_bad++;
                $display("FAIL conflict cyc %0d %s got %b expected %0d", chk[i][0],
                         bit_name[chk[i][1]], hist[chk[i][0]][chk[i][1]], chk[i][2]);
            end
        end
        do_reset();
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        foreach (chk_idle[i]) begin
            n_cmp++;
            if (hist[chk_idle[i][0]][chk_idle[i][1]] !== 1'(chk_idle[i][2])) begin
                n_bad++;
                $display("FAIL idle_en_wr cyc %0d %s got %b expected %0d", chk_idle[i][0],
                         bit_name[chk_idle[i][1]], hist[chk_idle[i][0]][chk_idle[i][1]], chk_idle[i][2]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (4000)
            tick($urandom_range(0, 40) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    endtask

    initial begin
        test_reset();
        test_program();
        test_back_to_back();
        test_erase();
        test_abort();
        test_conflict();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
